// File: rtl/packet_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// packet_tx : FIFO-buffered transmitter framing header/payload/trailer beats.
// Rev 1.0
// ----------------------------------------------------------------------------
module packet_tx #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter int DEPTH     = 8,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [BUS_SIZE-1:0] wr_data,
  input  logic                start,
  input  logic                err_inj,
  output logic [BUS_SIZE-1:0] data_bus,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                empty,
  output logic [CW-1:0]       count
);

  localparam int SW = (WORD_NUM - 1) * WORD_SIZE;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [BUS_SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_len;
  logic [CW-1:0]       r_beat;
  logic [SW-1:0]       r_seq;
  logic [BUS_SIZE-1:0] r_bus;
  logic [BUS_SIZE-1:0] w_bus_next;
  logic                w_push;
  logic                w_pop;
  logic                w_launch;
  logic                w_seq_inc;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign data_bus = r_bus;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_TRAILER);
  assign w_push   = wr_en && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The bus is registered from the next-state decode so each beat appears
  // in the same cycle as the state that owns it; a pop happens on the edge
  // that loads its beat onto the bus.
  always_comb begin
    w_state_next = r_state;
    w_bus_next   = '0;
    w_pop        = 1'b0;
    w_launch     = 1'b0;
    w_seq_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !empty) begin
          w_state_next = S_HEADER;
          w_launch     = 1'b1;
          w_bus_next   = {(err_inj ? {WORD_SIZE{1'b0}} : {WORD_SIZE{1'b1}}), r_seq};
        end
      end
      S_HEADER: begin
        w_state_next = S_PAYLOAD;
        w_pop        = 1'b1;
        w_bus_next   = r_mem[r_rptr];
      end
      S_PAYLOAD: begin
        if (r_beat == r_len) begin
          w_state_next = S_TRAILER;
          w_bus_next   = {SW'(r_len), {WORD_SIZE{1'b1}}};
        end else begin
          w_pop      = 1'b1;
          w_bus_next = r_mem[r_rptr];
        end
      end
      S_TRAILER: begin
        w_state_next = S_IDLE;
        w_seq_inc    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_seq   <= '0;
      r_bus   <= '0;
    end else begin
      r_bus   <= w_bus_next;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_beat <= r_beat + CW'(1);
      end
      if (w_launch) begin
        r_len  <= r_count;
        r_beat <= '0;
      end
      if (w_seq_inc) begin
        r_seq <= r_seq + SW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_packet_tx : directed table and sequence checks for packet_tx.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_packet_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        start;
  logic        err_inj;
  logic [15:0] data_bus;
  logic        busy;
  logic        done;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  packet_tx dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .start    (start),
    .err_inj  (err_inj),
    .data_bus (data_bus),
    .busy     (busy),
    .done     (done),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic        st;
    logic [15:0] wd;
    logic [15:0] bus;
    logic        bsy;
    logic        dn;
    logic        ful;
    logic        emp;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic wr, input logic st,
                              input logic [15:0] wd, input logic [15:0] bus,
                              input logic bsy, input logic dn, input logic ful,
                              input logic emp, input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.wr = wr; v.st = st; v.wd = wd; v.bus = bus;
    v.bsy = bsy; v.dn = dn; v.ful = ful; v.emp = emp; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic launch(input logic err);
    start   = 1'b1;
    err_inj = err;
    tick();
    start   = 1'b0;
    err_inj = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] beats [8];

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; err_inj = 1'b0;

    // Basic three-beat packet, then two back-to-back one-beat packets.
    //                rst wr st  wd        bus       bsy dn fl em cnt
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd0));
    tbl.push_back(mk(0, 1, 0, 16'hA1A1, 16'h0000, 0, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 1, 0, 16'hB2B2, 16'h0000, 0, 0, 0, 0, 4'd2));
    tbl.push_back(mk(0, 1, 0, 16'hC3C3, 16'h0000, 0, 0, 0, 0, 4'd3));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 16'hF000, 1, 0, 0, 0, 4'd3));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'hA1A1, 1, 0, 0, 0, 4'd2));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'hB2B2, 1, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'hC3C3, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h003F, 1, 1, 0, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd0));
    tbl.push_back(mk(0, 1, 0, 16'hD4D4, 16'h0000, 0, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 16'hF000, 1, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 1, 1, 16'hE5E5, 16'hD4D4, 1, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 16'h001F, 1, 1, 0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 16'hF001, 1, 0, 0, 0, 4'd1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'hE5E5, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h001F, 1, 1, 0, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst;
      wr_en   = tbl[i].wr;
      start   = tbl[i].st;
      wr_data = tbl[i].wd;
      tick();
      chk($sformatf("vec%0d.bus", i),   data_bus, tbl[i].bus);
      chk($sformatf("vec%0d.busy", i),  busy,     tbl[i].bsy);
      chk($sformatf("vec%0d.done", i),  done,     tbl[i].dn);
      chk($sformatf("vec%0d.full", i),  full,     tbl[i].ful);
      chk($sformatf("vec%0d.empty", i), empty,    tbl[i].emp);
      chk($sformatf("vec%0d.count", i), count,    tbl[i].cnt);
    end
    reset = 1'b0; wr_en = 1'b0; start = 1'b0;

    // Fill to DEPTH, drop a ninth write, send all eight.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      beats[i] = 16'h9000 + 16'(i) * 16'h0111;
      push(beats[i]);
    end
    chk("fill.full", full, 1'b1);
    chk("fill.count", count, 4'd8);
    push(16'hDEAD);
    chk("overfill.full", full, 1'b1);
    chk("overfill.count", count, 4'd8);
    launch(1'b0);
    chk("full_pkt.hdr", data_bus, 16'hF000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("full_pkt.beat%0d", i), data_bus, beats[i]);
    end
    tick();
    chk("full_pkt.trl", data_bus, 16'h008F);
    chk("full_pkt.done", done, 1'b1);
    tick();
    chk("full_pkt.idle", data_bus, 16'h0000);
    chk("full_pkt.empty", empty, 1'b1);

    // Beat written mid-packet waits for the next packet.
    push(16'h4441);
    push(16'h4442);
    launch(1'b0);
    chk("late.hdr", data_bus, 16'hF001);
    wr_en = 1'b1; wr_data = 16'h4443;
    tick();
    wr_en = 1'b0;
    chk("late.b0", data_bus, 16'h4441);
    tick();
    chk("late.b1", data_bus, 16'h4442);
    tick();
    chk("late.trl", data_bus, 16'h002F);
    tick();
    chk("late.count", count, 4'd1);
    launch(1'b0);
    chk("late.hdr2", data_bus, 16'hF002);
    tick();
    chk("late.b2", data_bus, 16'h4443);
    tick();
    chk("late.trl2", data_bus, 16'h001F);
    tick();

    // Corrupted header still advances the sequence.
    push(16'h5551);
    launch(1'b1);
    chk("err.hdr", data_bus, 16'h0003);
    tick();
    chk("err.b0", data_bus, 16'h5551);
    tick();
    chk("err.trl", data_bus, 16'h001F);
    tick();
    push(16'h6661);
    launch(1'b0);
    chk("err.next_hdr", data_bus, 16'hF004);
    tick();
    tick();
    tick();

    // Reset during payload aborts and clears everything.
    push(16'h7771);
    push(16'h7772);
    push(16'h7773);
    launch(1'b0);
    chk("abort.hdr", data_bus, 16'hF005);
    tick();
    chk("abort.b0", data_bus, 16'h7771);
    do_reset();
    chk("abort.bus", data_bus, 16'h0000);
    chk("abort.count", count, 4'd0);
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.empty", empty, 1'b1);
    push(16'h8881);
    launch(1'b0);
    chk("abort.hdr2", data_bus, 16'hF000);
    tick();
    chk("abort.b_new", data_bus, 16'h8881);
    tick();
    chk("abort.trl", data_bus, 16'h001F);
    tick();
    chk("abort.idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
